mem_access_unit: RTL and testbench

Load/store stage sitting directly downstream of the ALU in the MiniRiscV datapath. It takes the ALU's effective address plus the store operand and the decoded memory controls, runs one aligned access on a simple req/ack data bus, and returns sign- or zero-extended load data for writeback. While an access is outstanding it stalls the core. It reports misaligned, illegal and timed-out accesses as faults.

---
 rtl/mem_access_unit_pkg.sv | 34 +++
 rtl/mem_lane_align.sv | 53 +++++
 rtl/mem_access_unit.sv | 147 ++++++++++++++
 tb/tb_mem_access_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the MiniRiscV load/store path: funct3 size/sign codes,
// the access FSM states and the legality/alignment checks used by decode.
package mem_access_unit_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DONE
  } state_t;

  // Unsigned variants exist only for loads; stores accept b/h/w.
  function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !is_store;
      default:          return 1'b0;
    endcase
  endfunction

  function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_H, F3_HU: return !off[0];
      F3_W:        return off == 2'b00;
      default:     return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store data replication/strobes on the way out,
// load lane extraction and sign/zero extension on the way back.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]  store_f3,
  input  logic [1:0]  store_off,
  input  logic [31:0] store_data,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  input  logic [2:0]  load_f3,
  input  logic [1:0]  load_off,
  input  logic [31:0] rdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    wdata = store_data;
    wstrb = 4'b1111;
    case (store_f3)
      F3_B: begin
        wdata = {4{store_data[7:0]}};
        wstrb = 4'b0001 << store_off;
      end
      F3_H: begin
        wdata = {2{store_data[15:0]}};
        wstrb = store_off[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  assign byte_lane = rdata[{load_off, 3'b000} +: 8];
  assign half_lane = load_off[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    load_data = '0;
    case (load_f3)
      F3_B:    load_data = {{24{byte_lane[7]}}, byte_lane};
      F3_BU:   load_data = {24'b0, byte_lane};
      F3_H:    load_data = {{16{half_lane[15]}}, half_lane};
      F3_HU:   load_data = {16'b0, half_lane};
      F3_W:    load_data = rdata;
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store stage: decodes one aligned access, runs it on a req/ack bus with
// a timeout, stalls the core meanwhile and returns extended load data.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] ReadData2,
  output logic        Stall,
  output logic [31:0] LoadData,
  output logic        LoadValid,
  output logic        AccessFault,
  output logic        BusReq,
  output logic        BusWe,
  output logic [31:0] BusAddr,
  output logic [31:0] BusWData,
  output logic [3:0]  BusWStrb,
  input  logic        BusAck,
  input  logic [31:0] BusRData
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q;
  logic [29:0] addr_q;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] rdata_q;
  logic        fault_q;

  logic        access, legal, timeout_hit;
  logic [31:0] wdata_c, load_ext;
  logic [3:0]  wstrb_c;

  // Gating with rst_n keeps the combinational IDLE outputs quiet during reset.
  assign access      = (MemRead | MemWrite) & rst_n;
  assign legal       = f3_legal(funct3, MemWrite) && is_aligned(funct3, ALUResult[1:0]);
  assign timeout_hit = (cnt_q == TIMEOUT_LAST);

  mem_lane_align u_lane (
    .store_f3   (funct3),
    .store_off  (ALUResult[1:0]),
    .store_data (ReadData2),
    .wdata      (wdata_c),
    .wstrb      (wstrb_c),
    .load_f3    (f3_q),
    .load_off   (off_q),
    .rdata      (rdata_q),
    .load_data  (load_ext)
  );

  always_comb begin
    state_d     = state_q;
    Stall       = 1'b0;
    LoadData    = '0;
    LoadValid   = 1'b0;
    AccessFault = 1'b0;
    BusReq      = 1'b0;
    BusWe       = 1'b0;
    BusAddr     = '0;
    BusWData    = '0;
    BusWStrb    = '0;
    case (state_q)
      ST_IDLE: begin
        if (access) begin
          if (!legal) begin
            AccessFault = 1'b1;
          end else begin
            Stall   = 1'b1;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        Stall    = 1'b1;
        BusReq   = 1'b1;
        BusWe    = we_q;
        BusAddr  = {addr_q, 2'b00};
        BusWData = wdata_q;
        BusWStrb = wstrb_q;
        if (BusAck || timeout_hit) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (fault_q) begin
          AccessFault = 1'b1;
        end else if (!we_q) begin
          LoadValid = 1'b1;
          LoadData  = load_ext;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the datapath registers are reset along with the FSM so a reset in
  // the middle of an access never leaves stale data visible afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      off_q   <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (access && legal) begin
            addr_q  <= ALUResult[31:2];
            off_q   <= ALUResult[1:0];
            f3_q    <= funct3;
            we_q    <= MemWrite;
            wdata_q <= MemWrite ? wdata_c : '0;
            wstrb_q <= MemWrite ? wstrb_c : '0;
            cnt_q   <= '0;
            fault_q <= 1'b0;
          end
        end
        ST_REQ: begin
          cnt_q <= cnt_q + 8'd1;
          if (BusAck && !we_q) rdata_q <= BusRData;
          if (!BusAck && timeout_hit) fault_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: the driver queues expected bus
// transactions and load/fault responses, a negedge monitor pops and compares.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk, rst_n;
  logic        MemRead, MemWrite;
  logic [2:0]  funct3;
  logic [31:0] ALUResult, ReadData2;
  logic        Stall, LoadValid, AccessFault;
  logic [31:0] LoadData;
  logic        BusReq, BusWe, BusAck;
  logic [31:0] BusAddr, BusWData, BusRData;
  logic [3:0]  BusWStrb;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          len;
  } bus_exp_t;

  typedef struct {
    logic        fault;
    logic [31:0] data;
  } rsp_exp_t;

  bus_exp_t bus_q[$];
  rsp_exp_t rsp_q[$];

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .funct3      (funct3),
    .ALUResult   (ALUResult),
    .ReadData2   (ReadData2),
    .Stall       (Stall),
    .LoadData    (LoadData),
    .LoadValid   (LoadValid),
    .AccessFault (AccessFault),
    .BusReq      (BusReq),
    .BusWe       (BusWe),
    .BusAddr     (BusAddr),
    .BusWData    (BusWData),
    .BusWStrb    (BusWStrb),
    .BusAck      (BusAck),
    .BusRData    (BusRData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push_bus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input int len);
    bus_exp_t e;
    e.we = we; e.addr = addr; e.wdata = wdata; e.strb = strb; e.len = len;
    bus_q.push_back(e);
  endtask

  task automatic push_rsp(input logic fault, input logic [31:0] data);
    rsp_exp_t e;
    e.fault = fault; e.data = data;
    rsp_q.push_back(e);
  endtask

  // Issue one access; ack_k is the REQ cycle (1-based) carrying BusAck, 0 = none.
  task automatic run(input string name, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] rs2, input int ack_k,
                     input logic [31:0] rdata, input int exp_stall);
    int   stalls = 0;
    int   cyc    = 0;
    logic done   = 1'b0;
    @(posedge clk); #1;
    MemRead = !we; MemWrite = we; funct3 = f3;
    ALUResult = addr; ReadData2 = rs2; BusRData = rdata; BusAck = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (!Stall) begin
        done = 1'b1;
      end else begin
        stalls++;
        @(posedge clk); #1;
        cyc++;
        BusAck = (cyc == ack_k);
      end
    end
    check({name, "_finished"}, 32'(done), 32'd1);
    #1;
    MemRead = 1'b0; MemWrite = 1'b0; BusAck = 1'b0;
    check({name, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
  endtask

  // Monitor: compares each bus request and each LoadValid/AccessFault pulse.
  initial begin : monitor
    bus_exp_t cur;
    logic     prev_req = 1'b0;
    int       req_len  = 0;
    cur = '{we: 1'b0, addr: '0, wdata: '0, strb: '0, len: 0};
    forever begin
      @(negedge clk);
      if (BusReq) begin
        if (!prev_req) begin
          if (bus_q.size() == 0) begin
            check("bus_unexpected_req", 32'(BusReq), 32'd0);
          end else begin
            cur = bus_q.pop_front();
            check("bus_we", 32'(BusWe), 32'(cur.we));
            check("bus_addr", BusAddr, cur.addr);
            check("bus_wstrb", 32'(BusWStrb), 32'(cur.strb));
            if (cur.we) check("bus_wdata", BusWData, cur.wdata);
          end
          req_len = 1;
        end else begin
          req_len++;
          check("bus_addr_stable", BusAddr, cur.addr);
        end
      end else if (prev_req) begin
        check("bus_req_cycles", 32'(req_len), 32'(cur.len));
      end
      prev_req = BusReq;

      if (LoadValid || AccessFault) begin
        if (rsp_q.size() == 0) begin
          check("rsp_unexpected", 32'(LoadValid | AccessFault), 32'd0);
        end else begin
          rsp_exp_t r;
          r = rsp_q.pop_front();
          check("rsp_fault", 32'(AccessFault), 32'(r.fault));
          check("rsp_valid", 32'(LoadValid), 32'(!r.fault));
          check("rsp_data", LoadData, r.data);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    rst_n = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; funct3 = '0;
    ALUResult = '0; ReadData2 = '0; BusAck = 1'b0; BusRData = '0;
    #12;
    check("rst_stall", 32'(Stall), 32'd0);
    check("rst_busreq", 32'(BusReq), 32'd0);
    check("rst_loadvalid", 32'(LoadValid), 32'd0);
    check("rst_fault", 32'(AccessFault), 32'd0);
    check("rst_loaddata", LoadData, 32'd0);
    check("rst_busaddr", BusAddr, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    push_bus(1'b1, 32'h100, 32'hDEADBEEF, 4'b1111, 3);
    run("sw", 1'b1, F3_W, 32'h100, 32'hDEADBEEF, 3, 32'h0, 4);

    push_bus(1'b0, 32'h200, 32'h0, 4'b0000, 1);
    push_rsp(1'b0, 32'hFFFFFF80);
    run("lb", 1'b0, F3_B, 32'h203, 32'h0, 1, 32'h80FF0000, 2);

    push_bus(1'b0, 32'h200, 32'h0, 4'b0000, 1);
    push_rsp(1'b0, 32'h00000080);
    run("lbu", 1'b0, F3_BU, 32'h203, 32'h0, 1, 32'h80FF0000, 2);

    push_bus(1'b0, 32'h200, 32'h0, 4'b0000, 1);
    push_rsp(1'b0, 32'hFFFF80FF);
    run("lh", 1'b0, F3_H, 32'h202, 32'h0, 1, 32'h80FF0000, 2);

    push_bus(1'b0, 32'h200, 32'h0, 4'b0000, 2);
    push_rsp(1'b0, 32'h000080FF);
    run("lhu", 1'b0, F3_HU, 32'h202, 32'h0, 2, 32'h80FF0000, 3);

    push_bus(1'b0, 32'h204, 32'h0, 4'b0000, 2);
    push_rsp(1'b0, 32'h12345678);
    run("lw", 1'b0, F3_W, 32'h204, 32'h0, 2, 32'h12345678, 3);

    push_bus(1'b1, 32'h10, 32'hABCDABCD, 4'b1100, 1);
    run("sh", 1'b1, F3_H, 32'h12, 32'h0000ABCD, 1, 32'h0, 2);

    push_bus(1'b1, 32'h30, 32'h5A5A5A5A, 4'b0010, 2);
    run("sb", 1'b1, F3_B, 32'h31, 32'h1234565A, 2, 32'h0, 3);

    push_rsp(1'b1, 32'h0);
    run("lw_misaligned", 1'b0, F3_W, 32'h101, 32'h0, 0, 32'h0, 0);
    push_rsp(1'b1, 32'h0);
    run("store_f3_3", 1'b1, 3'd3, 32'h8, 32'h55, 0, 32'h0, 0);
    push_rsp(1'b1, 32'h0);
    run("load_f3_6", 1'b0, 3'd6, 32'h0, 32'h0, 0, 32'h0, 0);
    push_rsp(1'b1, 32'h0);
    run("lh_misaligned", 1'b0, F3_H, 32'h203, 32'h0, 0, 32'h0, 0);
    push_rsp(1'b1, 32'h0);
    run("store_f3_bu", 1'b1, F3_BU, 32'h0, 32'h77, 0, 32'h0, 0);

    push_bus(1'b0, 32'h300, 32'h0, 4'b0000, 4);
    push_rsp(1'b1, 32'h0);
    run("lw_timeout", 1'b0, F3_W, 32'h300, 32'h0, 0, 32'h0, 5);

    // Reset while a load is in REQ, then a stray ack after release.
    @(posedge clk); #1;
    MemRead = 1'b1; funct3 = F3_W; ALUResult = 32'h40; BusRData = 32'h11111111;
    @(posedge clk); #1;
    check("mid_busreq_before_rst", 32'(BusReq), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busreq", 32'(BusReq), 32'd0);
    check("mid_rst_stall", 32'(Stall), 32'd0);
    MemRead = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    BusAck = 1'b1;
    @(posedge clk); #1;
    BusAck = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stray_ack_loadvalid", 32'(LoadValid), 32'd0);
      check("stray_ack_busreq", 32'(BusReq), 32'd0);
    end

    push_bus(1'b0, 32'h200, 32'h0, 4'b0000, 2);
    push_rsp(1'b0, 32'h0000007F);
    run("lb_after_rst", 1'b0, F3_B, 32'h203, 32'h0, 2, 32'h7F000000, 3);

    repeat (3) @(posedge clk);
    #1;
    check("bus_q_drained", 32'(bus_q.size()), 32'd0);
    check("rsp_q_drained", 32'(rsp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
